shift_serializer: RTL and testbench

Parametrised full-duplex shift engine: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out serially while simultaneously shifting WIDTH bits in. It returns the received word with a one-cycle valid pulse. It replaces fixed-depth DFF shift chains wherever a design needs framed, counted serial transfer (SPI-style links, serial loopback, bit-level test paths).

---
 rtl/shift_ser_pkg.sv | 7 +
 rtl/shift_serializer.sv | 72 +++++++
 tb/tb_shift_serializer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/shift_ser_pkg.sv
// shift_ser_pkg: shared state encoding and counter sizing for shift_serializer
package shift_ser_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/shift_serializer.sv
// shift_serializer: full-duplex framed shift engine with valid/ready load and rx pulse
// Optional SHIFT_SER_LSB_FIRST_EN adds a per-frame lsb_first input.
module shift_serializer
  import shift_ser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sin,
  output logic             sout,
  output logic             busy,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data
`ifdef SHIFT_SER_LSB_FIRST_EN
  ,
  input  logic             lsb_first
`endif
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             w_lsb;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_next;
`ifdef SHIFT_SER_LSB_FIRST_EN
  logic r_lsb;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_lsb <= 1'b0;
    else if (w_accept) r_lsb <= lsb_first;
  assign w_lsb = r_lsb;
`else
  assign w_lsb = 1'b0;
`endif
  assign busy       = (r_state == ST_SHIFT);
  assign w_last     = busy && (r_cnt == LAST);
  assign load_ready = !busy || w_last;
  assign w_accept   = load_valid && load_ready;
  assign w_next     = w_lsb ? {sin, r_shreg[WIDTH-1:1]} : {r_shreg[WIDTH-2:0], sin};
  assign sout       = busy ? (w_lsb ? r_shreg[0] : r_shreg[WIDTH-1]) : 1'b0;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  // A load on the last shift edge wins over the shift so frames stream gaplessly.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= w_last;
      if (w_last) r_rx_data <= w_next;
      if (w_accept) begin
        r_shreg <= load_data;
        r_cnt   <= '0;
        r_state <= ST_SHIFT;
      end else if (busy) begin
        r_shreg <= w_next;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) r_state <= ST_IDLE;
      end
    end
endmodule

// File: tb/tb_shift_serializer.sv
// tb_shift_serializer: directed + random frames checked against a bit-order model
module tb_shift_serializer;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_valid = 1'b0;
  logic sin = 1'b0;
  logic [W-1:0] load_data = '0;
  logic load_ready, sout, busy, rx_valid;
  logic [W-1:0] rx_data;
  int n_vec = 0;
  int n_err = 0;
`ifdef SHIFT_SER_LSB_FIRST_EN
  logic lsb_first = 1'b0;
`endif

  shift_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .sin(sin), .sout(sout), .busy(busy),
    .rx_valid(rx_valid), .rx_data(rx_data)
`ifdef SHIFT_SER_LSB_FIRST_EN
    , .lsb_first(lsb_first)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One frame: sout follows the word in transmit order, the k-th sampled sin bit
  // lands at the k-th transmit position, rx_valid pulses once after WIDTH shifts.
  task automatic frame(input logic [W-1:0] d, input logic [W-1:0] s, input bit loop,
                       input bit lsb, input int pulse);
    logic [W-1:0] exp_rx;
    int idx;
    @(negedge clk);
    chk("ready_idle", 32'(load_ready), 32'd1);
    load_valid = 1'b1;
    load_data  = d;
`ifdef SHIFT_SER_LSB_FIRST_EN
    lsb_first = lsb;
`endif
    exp_rx = '0;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      load_valid = (k == pulse);
      if (k == pulse) load_data = '1;
      idx = lsb ? k : W - 1 - k;
      chk("busy", 32'(busy), 32'd1);
      chk("sout", 32'(sout), 32'(d[idx]));
      chk("rx_valid_low", 32'(rx_valid), 32'd0);
      if (k == pulse) chk("ready_mid", 32'(load_ready), 32'd0);
      sin = loop ? sout : s[k];
      exp_rx[idx] = loop ? d[idx] : s[k];
    end
    @(negedge clk);
    load_valid = 1'b0;
    chk("rx_valid", 32'(rx_valid), 32'd1);
    chk("rx_data", 32'(rx_data), 32'(exp_rx));
    chk("busy_end", 32'(busy), 32'd0);
    chk("ready_end", 32'(load_ready), 32'd1);
    @(negedge clk);
    chk("rx_valid_once", 32'(rx_valid), 32'd0);
    chk("rx_hold", 32'(rx_data), 32'(exp_rx));
  endtask

  initial begin
    logic [W-1:0] w0, w1;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sout", 32'(sout), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_rxv", 32'(rx_valid), 32'd0);
    chk("rst_rxd", 32'(rx_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    frame(8'hA5, '0, 1'b1, 1'b0, -1);
    frame(8'h00, 8'hFF, 1'b0, 1'b0, -1);
    // back-to-back: load_valid held through the first frame's last shift
    w0 = 8'h3C;
    w1 = 8'hC3;
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = w0;
    for (int c = 0; c <= 2 * W; c++) begin
      @(negedge clk);
      load_data  = w1;
      load_valid = (c < W);
      chk("b2b_busy", 32'(busy), 32'(c < 2 * W));
      chk("b2b_rxv", 32'(rx_valid), 32'(c == W || c == 2 * W));
      if (c < 2 * W) chk("b2b_sout", 32'(sout), 32'(c < W ? w0[W-1-c] : w1[2*W-1-c]));
      if (c == W) chk("b2b_rx0", 32'(rx_data), 32'(w0));
      if (c == 2 * W) chk("b2b_rx1", 32'(rx_data), 32'(w1));
      sin = sout;
    end
    load_valid = 1'b0;
    frame(8'h11, 8'(~$urandom), 1'b0, 1'b0, 3);
    // reset mid-frame after rx_data already holds a nonzero word
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 8'h5A;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_sout", 32'(sout), 32'd0);
    chk("mid_rst_rxv", 32'(rx_valid), 32'd0);
    chk("mid_rst_rxd", 32'(rx_data), 32'd0);
    chk("mid_rst_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("post_rst_rxv", 32'(rx_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    for (int i = 0; i < 12; i++) frame(8'($urandom), 8'($urandom), 1'b0, 1'b0, -1);
`ifdef SHIFT_SER_LSB_FIRST_EN
    frame(8'h01, '0, 1'b1, 1'b1, -1);
    for (int i = 0; i < 6; i++) frame(8'($urandom), 8'($urandom), 1'b0, 1'($urandom), -1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
